uart_receiver: RTL and testbench

UART receive half of the serial link. It is the counterpart of the transmitter block and uses the same CLOCKS_PER_PULSE bit timing. It frames 8N1 serial data: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high). It synchronises the asynchronous rx line, samples each bit at mid-bit, and presents each received byte with a one-cycle valid strobe.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_receiver.sv | 114 +++++++++++
 tb/tb_uart_receiver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART serial link blocks.
package uart_pkg;

    localparam int DATA_WIDTH = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input; both flops reset to RESET_VAL.
module uart_sync2
    import uart_pkg::*;
#(
    parameter logic RESET_VAL = IDLE_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronised rx, mid-bit sampling, one-cycle data_valid / frame_err strobes.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_PULSE - 1);

    logic                  rx_s;
    rx_state_t             state;
    logic [CW-1:0]         cnt;
    logic [2:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shreg;

    uart_sync2 #(
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_s != IDLE_LEVEL) begin
                        state   <= START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        // A line that is high again at mid-start-bit was only a glitch.
                        if (rx_s == IDLE_LEVEL) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        // Good stop returns to IDLE mid-stop-bit so back-to-back starts are caught.
                        if (rx_s == IDLE_LEVEL) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            rx_busy    <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s == IDLE_LEVEL) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at P=16 and P=4, with directed frames.
module tb_uart_receiver;

    localparam int P16 = 16;
    localparam int P4  = 4;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at_edge;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] do_a, do_b;
    logic       dv_a, dv_b, fe_a, fe_b, busy_a, busy_b;

    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;

    uart_receiver #(
        .CLOCKS_PER_PULSE(P16)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_a),
        .data_out  (do_a),
        .data_valid(dv_a),
        .frame_err (fe_a),
        .rx_busy   (busy_a)
    );

    uart_receiver #(
        .CLOCKS_PER_PULSE(P4)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_b),
        .data_out  (do_b),
        .data_valid(dv_b),
        .frame_err (fe_b),
        .rx_busy   (busy_b)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_cnt = edge_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic on_event(input int id, input logic dv, input logic fe, input logic [7:0] d);
        exp_t x;
        bit   empty;
        check("strobes_exclusive", int'(dv & fe), 0);
        empty = (id == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        if (empty) begin
            check(id == 0 ? "unexpected_event_a" : "unexpected_event_b", 1, 0);
        end else begin
            x = (id == 0) ? q_a.pop_front() : q_b.pop_front();
            check("event_kind_err", int'(fe), int'(x.is_err));
            check("data_out", int'(d), int'(x.data));
            check("event_edge", edge_cnt, x.at_edge);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst && (dv_a || fe_a)) on_event(0, dv_a, fe_a, do_a);
    end

    initial forever begin
        @(negedge clk);
        if (!rst && (dv_b || fe_b)) on_event(1, dv_b, fe_b, do_b);
    end

    task automatic drive_bit(input int id, input logic v, input int n);
        if (id == 0) rx_a = v;
        else rx_b = v;
        repeat (n) @(negedge clk);
    endtask

    // Call right after a negedge; the first posedge that sees the start bit is edge_cnt+1.
    task automatic send_frame(input int id, input logic [7:0] b, input bit good);
        int   p;
        int   e;
        exp_t x;
        p = (id == 0) ? P16 : P4;
        e = edge_cnt + 1;
        x.at_edge = e + 2 + p / 2 + 9 * p;
        x.is_err  = !good;
        x.data    = good ? b : ((id == 0) ? last_a : last_b);
        if (id == 0) q_a.push_back(x);
        else q_b.push_back(x);
        if (good && id == 0) last_a = b;
        if (good && id == 1) last_b = b;
        drive_bit(id, 1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(id, b[i], p);
        drive_bit(id, good, p);
    endtask

    initial begin
        int e;
        int t0;

        #1 rst = 1'b1;
        #1;
        check("reset_data_out_a", int'(do_a), 0);
        check("reset_valid_a", int'(dv_a), 0);
        check("reset_ferr_a", int'(fe_a), 0);
        check("reset_busy_a", int'(busy_a), 0);
        check("reset_data_out_b", int'(do_b), 0);
        check("reset_busy_b", int'(busy_b), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Loopback-style single byte.
        send_frame(0, 8'b1010_1100, 1'b1);
        drive_bit(0, 1'b1, 2 * P16);
        check("busy_after_ac", int'(busy_a), 0);

        // Back-to-back bytes with no idle gap.
        send_frame(0, 8'h55, 1'b1);
        send_frame(0, 8'hFF, 1'b1);
        drive_bit(0, 1'b1, 2 * P16);

        // False start of P/4 cycles.
        e  = edge_cnt + 1;
        t0 = e + 2;
        drive_bit(0, 1'b0, P16 / 4);
        check("false_start_busy_high", int'(busy_a), 1);
        rx_a = 1'b1;
        while (edge_cnt < t0 + P16 / 2 - 1) @(negedge clk);
        check("false_start_busy_before", int'(busy_a), 1);
        @(negedge clk);
        check("false_start_busy_cleared", int'(busy_a), 0);
        drive_bit(0, 1'b1, 2 * P16);

        // Framing error followed by a held-low line, then a good frame.
        send_frame(0, 8'h3C, 1'b0);
        drive_bit(0, 1'b0, 3 * P16);
        check("break_busy_held", int'(busy_a), 1);
        rx_a = 1'b1;
        for (int k = 0; k < 10 && busy_a; k++) @(negedge clk);
        check("break_busy_released", int'(busy_a), 0);
        drive_bit(0, 1'b1, P16);
        send_frame(0, 8'h0F, 1'b1);
        drive_bit(0, 1'b1, 2 * P16);

        // Reset during data bit 4 of 8'hA5 (LSB first: 1,0,1,0, then bit 4 = 0).
        drive_bit(0, 1'b0, P16);
        drive_bit(0, 1'b1, P16);
        drive_bit(0, 1'b0, P16);
        drive_bit(0, 1'b1, P16);
        drive_bit(0, 1'b0, P16);
        drive_bit(0, 1'b0, P16 / 2);
        #2 rst = 1'b1;
        #1;
        check("midframe_rst_data_out", int'(do_a), 0);
        check("midframe_rst_valid", int'(dv_a), 0);
        check("midframe_rst_ferr", int'(fe_a), 0);
        check("midframe_rst_busy", int'(busy_a), 0);
        rx_a   = 1'b1;
        last_a = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_bit(0, 1'b1, 3 * P16);
        check("post_rst_busy", int'(busy_a), 0);
        send_frame(0, 8'h5A, 1'b1);
        drive_bit(0, 1'b1, 2 * P16);

        // Boundary bytes at P=4.
        send_frame(1, 8'h00, 1'b1);
        drive_bit(1, 1'b1, P4);
        send_frame(1, 8'hFF, 1'b1);
        drive_bit(1, 1'b1, 4 * P4);

        check("pending_expect_a", q_a.size(), 0);
        check("pending_expect_b", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
